// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings, FSM state type and byte-lane helpers for the SRAM responder.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian lane select; only meaningful for legal (aligned, supported) accesses.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: return 4'b0001 << a;
            HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// DEPTH x 32 storage with a byte-enable write port and an asynchronous read port.
module ahb_sram_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b])
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: address-phase capture, wait-state FSM, two-cycle ERROR,
// byte-lane writes and write-to-read forwarding for back-to-back beats.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        H_clk,
    input  logic        H_reset,
    input  logic        H_sel,
    input  logic        H_ready_in,
    input  logic [1:0]  H_trans,
    input  logic        H_write,
    input  logic [2:0]  H_size,
    input  logic [31:0] H_addr,
    input  logic [31:0] H_wdata,
    output logic        H_ready,
    output logic [1:0]  H_resp,
    output logic [31:0] H_rdata
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [3:0]    be_q, be_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   offset;
    logic          aligned, legal, accept, load_rd, we;
    logic [AW-1:0] acc_idx, rd_idx;
    logic [31:0]   mem_rd, fwd_word;

    // Offset is unsigned: addresses below ADDR_BASE wrap high and fail the range test.
    assign offset  = H_addr - ADDR_BASE;
    assign acc_idx = offset[AW+1:2];

    always_comb begin
        aligned = 1'b0;
        case (H_size)
            HSIZE_BYTE: aligned = 1'b1;
            HSIZE_HALF: aligned = ~offset[0];
            HSIZE_WORD: aligned = (offset[1:0] == 2'b00);
            default:    aligned = 1'b0;
        endcase
    end

    assign legal  = (offset < SPAN) && aligned;
    assign accept = H_sel && H_ready_in &&
                    (H_trans == HTRANS_NONSEQ || H_trans == HTRANS_SEQ);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        H_ready = 1'b1;
        H_resp  = HRESP_OKAY;
        load_rd = 1'b0;
        rd_idx  = acc_idx;

        case (state_q)
            ST_WAIT: begin
                H_ready = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                    load_rd = ~write_q;
                    rd_idx  = idx_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                H_ready = 1'b0;
                H_resp  = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                H_resp  = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new address phase can only complete while this slave shows H_ready=1.
        if (accept && (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2)) begin
            if (legal) begin
                idx_d   = acc_idx;
                write_d = H_write;
                be_d    = byte_en(H_size, offset[1:0]);
                if (WAIT_STATES == 0) begin
                    state_d = ST_DATA;
                    load_rd = ~H_write;
                    rd_idx  = acc_idx;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end else begin
                state_d = ST_ERR1;
            end
        end
    end

    assign we = (state_q == ST_DATA) && write_q && !H_reset;

    // A read captured on the same edge as a committing write sees the merged word.
    assign fwd_word = (we && idx_q == rd_idx) ? merge_bytes(mem_rd, H_wdata, be_q) : mem_rd;
    assign rdata_d  = load_rd ? fwd_word : rdata_q;

    always_ff @(posedge H_clk) begin
        if (H_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    ahb_sram_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_i   (H_clk),
        .we_i    (we),
        .waddr_i (idx_q),
        .be_i    (be_q),
        .wdata_i (H_wdata),
        .raddr_i (rd_idx),
        .rdata_o (mem_rd)
    );

    assign H_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait and one two-wait instance share the bus; tgt picks the responder.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel0, sel2, tgt, wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr, wdata;
    logic        rdy0, rdy2, rdy_in;
    logic [1:0]  resp0, resp2;
    logic [31:0] rd0, rd2;

    int errors = 0;
    int checks = 0;

    assign rdy_in = tgt ? rdy2 : rdy0;

    ahb_sram_slave #(.DEPTH(256), .ADDR_BASE(32'h0), .WAIT_STATES(0)) u_w0 (
        .H_clk(clk), .H_reset(rst), .H_sel(sel0), .H_ready_in(rdy_in), .H_trans(trans),
        .H_write(wr), .H_size(size), .H_addr(addr), .H_wdata(wdata),
        .H_ready(rdy0), .H_resp(resp0), .H_rdata(rd0));

    ahb_sram_slave #(.DEPTH(256), .ADDR_BASE(32'h0), .WAIT_STATES(2)) u_w2 (
        .H_clk(clk), .H_reset(rst), .H_sel(sel2), .H_ready_in(rdy_in), .H_trans(trans),
        .H_write(wr), .H_size(size), .H_addr(addr), .H_wdata(wdata),
        .H_ready(rdy2), .H_resp(resp2), .H_rdata(rd2));

    logic [31:0] err_addr [4] = '{32'h0000_0002, 32'h0000_0400, 32'h0000_0000, 32'h0000_0001};
    logic [2:0]  err_size [4] = '{3'b010, 3'b010, 3'b011, 3'b001};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sel0 = 1'b0; sel2 = 1'b0; trans = 2'b00; wr = 1'b0; size = 3'b010; addr = 32'h0;
    endtask

    task automatic aphase(input logic w, input logic [2:0] sz, input logic [31:0] a);
        sel0 = ~tgt; sel2 = tgt; trans = 2'b10; wr = w; size = sz; addr = a;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        tgt = 1'b0;
        aphase(1'b1, sz, a); tick();
        idle_bus(); wdata = d; tick();
    endtask

    task automatic rd0_word(input logic [31:0] a, output logic [31:0] d,
                            output logic r, output logic [1:0] rs);
        tgt = 1'b0;
        aphase(1'b0, 3'b010, a); tick();
        idle_bus(); d = rd0; r = rdy0; rs = resp0; tick();
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d);
        tgt = 1'b1;
        aphase(1'b1, 3'b010, a); tick();
        idle_bus(); wdata = d; tick(); tick(); tick();
    endtask

    task automatic rd2_word(input logic [31:0] a, output logic [31:0] d);
        tgt = 1'b1;
        aphase(1'b0, 3'b010, a); tick();
        idle_bus(); tick(); tick();
        d = rd2; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_bus(); tick(); tick();
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b want 1", rdy0); end
        checks++; if (resp0 !== 2'b00) begin errors++; $display("FAIL rst_resp0 got %b want 00", resp0); end
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0 got %h want 0", rd0); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rst_ready2 got %b want 1", rdy2); end
        checks++; if (resp2 !== 2'b00) begin errors++; $display("FAIL rst_resp2 got %b want 00", resp2); end
        rst = 1'b0; tick();
    endtask

    task automatic test_basic_w0();
        logic [31:0] d; logic r; logic [1:0] rs;
        tgt = 1'b0;
        aphase(1'b1, 3'b010, 32'h10); tick();
        idle_bus(); wdata = 32'hDEAD_BEEF;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL w0_wr_ready got %b want 1", rdy0); end
        tick();
        rd0_word(32'h10, d, r, rs);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL w0_rd_ready got %b want 1", r); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL w0_rd_resp got %b want 00", rs); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL w0_rdata got %h want deadbeef", d); end
    endtask

    task automatic test_wait_states();
        wr2(32'h4, 32'hCAFE_F00D);
        tgt = 1'b1;
        aphase(1'b0, 3'b010, 32'h4); tick();
        idle_bus();
        checks++; if (rdy2 !== 1'b0 || resp2 !== 2'b00) begin errors++; $display("FAIL ws_n1 got rdy=%b resp=%b want 0/00", rdy2, resp2); end
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL ws_n2 got rdy=%b want 0", rdy2); end
        tick();
        checks++; if (rdy2 !== 1'b1 || resp2 !== 2'b00) begin errors++; $display("FAIL ws_n3 got rdy=%b resp=%b want 1/00", rdy2, resp2); end
        checks++; if (rd2 !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_rdata got %h want cafef00d", rd2); end
        tick();
        // BUSY to an out-of-range address must be ignored entirely
        sel2 = 1'b1; trans = 2'b01; wr = 1'b1; addr = 32'hFFFF_FFF0; tick();
        checks++; if (rdy2 !== 1'b1 || resp2 !== 2'b00) begin errors++; $display("FAIL ws_busy1 got rdy=%b resp=%b want 1/00", rdy2, resp2); end
        tick();
        checks++; if (rdy2 !== 1'b1 || resp2 !== 2'b00 || rd2 !== 32'hCAFE_F00D)
            begin errors++; $display("FAIL ws_busy2 got rdy=%b resp=%b rd=%h want 1/00/cafef00d", rdy2, resp2, rd2); end
        idle_bus(); tick();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; logic r; logic [1:0] rs;
        wr0(32'h10, 3'b010, 32'h1122_3344);
        wr0(32'h13, 3'b000, 32'hAA99_8877);
        rd0_word(32'h10, d, r, rs);
        checks++; if (d !== 32'hAA22_3344) begin errors++; $display("FAIL lane_b3 got %h want aa223344", d); end
        wr0(32'h12, 3'b001, 32'h5566_1234);
        rd0_word(32'h10, d, r, rs);
        checks++; if (d !== 32'h5566_3344) begin errors++; $display("FAIL lane_h1 got %h want 55663344", d); end
        wr0(32'h11, 3'b000, 32'h0000_BB00);
        rd0_word(32'h10, d, r, rs);
        checks++; if (d !== 32'h5566_BB44) begin errors++; $display("FAIL lane_b1 got %h want 5566bb44", d); end
        wr0(32'h10, 3'b001, 32'hFFFF_7788);
        rd0_word(32'h10, d, r, rs);
        checks++; if (d !== 32'h5566_7788) begin errors++; $display("FAIL lane_h0 got %h want 55667788", d); end
    endtask

    task automatic test_back_to_back();
        wr0(32'h20, 3'b010, 32'h0BAD_F00D);
        tgt = 1'b0;
        aphase(1'b1, 3'b010, 32'h20); tick();
        wdata = 32'h1234_5678; aphase(1'b0, 3'b010, 32'h20);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %b want 1", rdy0); end
        tick();
        idle_bus();
        checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00) begin errors++; $display("FAIL b2b_rd_resp got rdy=%b resp=%b want 1/00", rdy0, resp0); end
        checks++; if (rd0 !== 32'h1234_5678) begin errors++; $display("FAIL b2b_full got %h want 12345678", rd0); end
        tick();
        aphase(1'b1, 3'b000, 32'h21); tick();
        wdata = 32'h0000_AB00; aphase(1'b0, 3'b010, 32'h20); tick();
        idle_bus();
        checks++; if (rd0 !== 32'h1234_AB78) begin errors++; $display("FAIL b2b_merge got %h want 1234ab78", rd0); end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] d; logic r; logic [1:0] rs;
        wr0(32'h0, 3'b010, 32'h0102_0304);
        for (int i = 0; i < 4; i++) begin
            tgt = 1'b0;
            aphase(1'b1, err_size[i], err_addr[i]); tick();
            idle_bus(); wdata = 32'hFFFF_FFFF;
            checks++; if (rdy0 !== 1'b0 || resp0 !== 2'b01)
                begin errors++; $display("FAIL err1_%0d got rdy=%b resp=%b want 0/01", i, rdy0, resp0); end
            tick();
            checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b01)
                begin errors++; $display("FAIL err2_%0d got rdy=%b resp=%b want 1/01", i, rdy0, resp0); end
            tick();
            checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00)
                begin errors++; $display("FAIL errx_%0d got rdy=%b resp=%b want 1/00", i, rdy0, resp0); end
        end
        rd0_word(32'h0, d, r, rs);
        checks++; if (d !== 32'h0102_0304) begin errors++; $display("FAIL err_mem got %h want 01020304", d); end
        wr0(32'h3FC, 3'b010, 32'hA5A5_A5A5);
        rd0_word(32'h3FC, d, r, rs);
        checks++; if (d !== 32'hA5A5_A5A5 || rs !== 2'b00)
            begin errors++; $display("FAIL top_word got %h/%b want a5a5a5a5/00", d, rs); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic r; logic [1:0] rs;
        wr2(32'h8, 32'h1111_1111);
        tgt = 1'b1;
        aphase(1'b1, 3'b010, 32'h8); tick();
        idle_bus(); wdata = 32'h2222_2222;
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL rm_wait got rdy=%b want 0", rdy2); end
        rst = 1'b1; tick();
        checks++; if (rdy2 !== 1'b1 || resp2 !== 2'b00 || rd2 !== 32'h0)
            begin errors++; $display("FAIL rm_out got rdy=%b resp=%b rd=%h want 1/00/0", rdy2, resp2, rd2); end
        rst = 1'b0; tick(); tick(); tick();
        rd2_word(32'h8, d);
        checks++; if (d !== 32'h1111_1111) begin errors++; $display("FAIL rm_word2 got %h want 11111111", d); end
        wr0(32'h8, 3'b010, 32'h3333_3333);
        tgt = 1'b0;
        aphase(1'b1, 3'b010, 32'h8); tick();
        idle_bus(); wdata = 32'h4444_4444; rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if (rdy0 !== 1'b1 || resp0 !== 2'b00)
            begin errors++; $display("FAIL rm_out0 got rdy=%b resp=%b want 1/00", rdy0, resp0); end
        rd0_word(32'h8, d, r, rs);
        checks++; if (d !== 32'h3333_3333) begin errors++; $display("FAIL rm_word0 got %h want 33333333", d); end
    endtask

    initial begin
        rst = 1'b1; tgt = 1'b0; wdata = 32'h0; idle_bus();
        test_reset();
        test_basic_w0();
        test_wait_states();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
